// File: rtl/gpu_rect_copy_pkg.sv
// gpu_rect_copy_pkg: shared defaults, controller state and receiver phase encodings
// for the rectangle upload path.
`default_nettype none

package gpu_rect_copy_pkg;

   localparam int          DEF_RECT_COUNT_WIDTH = 2;
   localparam int unsigned DEF_RECT_BASE        = 32'h0000_0100;

   // Phase numbering equals the receiver's state numbering, one word per phase.
   localparam logic [2:0] PHASE_START  = 3'd0;
   localparam logic [2:0] PHASE_X      = 3'd1;
   localparam logic [2:0] PHASE_Y      = 3'd2;
   localparam logic [2:0] PHASE_WIDTH  = 3'd3;
   localparam logic [2:0] PHASE_HEIGHT = 3'd4;
   localparam logic [2:0] PHASE_COLOR  = 3'd5;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/gpu_rect_copy.sv
// gpu_rect_copy: streams the rectangle table from data memory into the GPU
// receiver on its fixed 6-cycle-per-rectangle schedule; rev 1.0.
`default_nettype none

module gpu_rect_copy
   import gpu_rect_copy_pkg::*;
#(
   parameter int          RECT_COUNT_WIDTH = DEF_RECT_COUNT_WIDTH,
   parameter int          ADDR_WIDTH       = 16,
   parameter int unsigned RECT_BASE        = DEF_RECT_BASE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   input  logic [15:0]           mem_rdata,
   output logic                  gpu_reset,
   output logic [15:0]           gpu_data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(RECT_BASE);

   state_e                      state_q;
   logic [2:0]                  phase_q;
   logic [RECT_COUNT_WIDTH-1:0] rect_q;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic                        mem_re_q;
   logic                        busy_q;
   logic                        gpu_reset_q;
   logic                        done_q;
   logic                        last_rect_d;

   assign last_rect_d = &rect_q;

   // addr_q is the address presented this cycle; it pauses on the HEIGHT->COLOR
   // step so the bus holds the colour address while reads are disabled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= PHASE_START;
         rect_q      <= '0;
         addr_q      <= BASE_ADDR;
         mem_re_q    <= 1'b0;
         busy_q      <= 1'b0;
         gpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q     <= ST_STREAM;
                  phase_q     <= PHASE_START;
                  rect_q      <= '0;
                  addr_q      <= BASE_ADDR;
                  mem_re_q    <= 1'b1;
                  busy_q      <= 1'b1;
                  gpu_reset_q <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (phase_q == PHASE_COLOR) begin
                  done_q <= 1'b0;
                  if (last_rect_d) begin
                     state_q     <= ST_IDLE;
                     phase_q     <= PHASE_START;
                     rect_q      <= '0;
                     addr_q      <= BASE_ADDR;
                     mem_re_q    <= 1'b0;
                     busy_q      <= 1'b0;
                     gpu_reset_q <= 1'b1;
                  end else begin
                     phase_q  <= PHASE_START;
                     rect_q   <= rect_q + RECT_COUNT_WIDTH'(1);
                     addr_q   <= addr_q + ADDR_WIDTH'(1);
                     mem_re_q <= 1'b1;
                  end
               end else begin
                  phase_q  <= phase_q + 3'd1;
                  mem_re_q <= (phase_q != PHASE_HEIGHT);
                  done_q   <= (phase_q == PHASE_HEIGHT) && last_rect_d;
                  if (phase_q != PHASE_HEIGHT) begin
                     addr_q <= addr_q + ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               mem_re_q    <= 1'b0;
               busy_q      <= 1'b0;
               gpu_reset_q <= 1'b1;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr  = addr_q;
   assign mem_re    = mem_re_q;
   assign busy      = busy_q;
   assign gpu_reset = gpu_reset_q;
   assign done      = done_q;
   assign gpu_data  = busy_q ? mem_rdata : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_gpu_rect_copy.sv
// tb_gpu_rect_copy: directed checks of gpu_rect_copy against hand-derived
// address/control schedules, with a behavioural memory and receiver.
`default_nettype none

module tb_gpu_rect_copy;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        start2;
   logic [15:0] mem_addr,  mem_addr2;
   logic        mem_re,    mem_re2;
   logic [15:0] mem_rdata, mem_rdata2;
   logic        gpu_reset, gpu_reset2;
   logic [15:0] gpu_data,  gpu_data2;
   logic        busy,      busy2;
   logic        done,      done2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gpu_rect_copy #(.RECT_COUNT_WIDTH(2), .ADDR_WIDTH(16), .RECT_BASE(32'h0100)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .gpu_reset(gpu_reset), .gpu_data(gpu_data), .busy(busy), .done(done)
   );

   gpu_rect_copy #(.RECT_COUNT_WIDTH(1), .ADDR_WIDTH(16), .RECT_BASE(32'hFFFE)) u_dut_wrap (
      .clk(clk), .reset(reset), .start(start2),
      .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_rdata(mem_rdata2),
      .gpu_reset(gpu_reset2), .gpu_data(gpu_data2), .busy(busy2), .done(done2)
   );

   // Memory holds word[a] = a with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_re)  mem_rdata  <= mem_addr;
      if (mem_re2) mem_rdata2 <= mem_addr2;
   end

   // Receiver stand-in: phase 0 is START, phases 1..5 latch x,y,w,h,colour.
   logic [2:0]  rx_phase;
   logic [1:0]  rx_rect;
   logic [15:0] rx_field [4][5];
   logic        rx_finish;
   assign rx_finish = !gpu_reset && (rx_phase == 3'd5) && (rx_rect == 2'd3);

   always @(posedge clk) begin
      if (gpu_reset) begin
         rx_phase <= 3'd0;
         rx_rect  <= 2'd0;
      end else begin
         if (rx_phase != 3'd0) rx_field[rx_rect][rx_phase - 3'd1] <= gpu_data;
         if (rx_phase == 3'd5) begin
            rx_phase <= 3'd0;
            rx_rect  <= rx_rect + 2'd1;
         end else begin
            rx_phase <= rx_phase + 3'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " gpu_reset"}, 32'(gpu_reset), 32'd1);
      check({tag, " busy"},      32'(busy),      32'd0);
      check({tag, " mem_re"},    32'(mem_re),    32'd0);
      check({tag, " mem_addr"},  32'(mem_addr),  32'h0100);
      check({tag, " done"},      32'(done),      32'd0);
      check({tag, " gpu_data"},  32'(gpu_data),  32'd0);
   endtask

   // Expected values for stream cycle k (1-based) of a copy based at 'base'.
   task automatic check_stream(input string tag, input int k, input int base, input int n);
      int p, r, a;
      p = (k - 1) % 6;
      r = (k - 1) / 6;
      a = (base + 5 * r + ((p < 5) ? p : 4)) & 32'hFFFF;
      if (base == 32'h0100) begin
         check({tag, " busy"},      32'(busy),      32'd1);
         check({tag, " gpu_reset"}, 32'(gpu_reset), 32'd0);
         check({tag, " mem_addr"},  32'(mem_addr),  32'(a));
         check({tag, " mem_re"},    32'(mem_re),    32'(p < 5));
         check({tag, " done"},      32'(done),      32'(k == 6 * n));
         if (p >= 1)
            check({tag, " gpu_data"}, 32'(gpu_data), 32'((base + 5 * r + p - 1) & 32'hFFFF));
      end else begin
         check({tag, " busy"},     32'(busy2),     32'd1);
         check({tag, " mem_addr"}, 32'(mem_addr2), 32'(a));
         check({tag, " done"},     32'(done2),     32'(k == 6 * n));
         if (p >= 1)
            check({tag, " gpu_data"}, 32'(gpu_data2), 32'((base + 5 * r + p - 1) & 32'hFFFF));
      end
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;

      // Reset, then idle with no start.
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0 || i == 5) check_idle("idle");
      end

      // Single copy: start sampled at edge T, stream occupies T+1..T+24.
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 26; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k <= 24) begin
            check_stream("copy", k, 32'h0100, 4);
            if (k == 24) check("rx finish vs done", 32'(rx_finish), 32'(done));
         end else begin
            check_idle("post-copy");
         end
      end
      for (int f = 0; f < 5; f++) begin
         check("rx rect0 field", 32'(rx_field[0][f]), 32'h0100 + 32'(f));
         check("rx rect3 field", 32'(rx_field[3][f]), 32'h010F + 32'(f));
      end

      // Start held high: second copy begins T+26, start on the done cycle ignored.
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         if (k == 50) start = 1'b0;
         if (k <= 24)       check_stream("held1", k, 32'h0100, 4);
         else if (k == 25)  check_idle("held gap");
         else if (k <= 49)  check_stream("held2", k - 25, 32'h0100, 4);
         else               check_idle("held end");
      end

      // Reset asserted mid rect 1.
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 8) check_stream("pre-abort", k, 32'h0100, 4);
      end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check_idle("abort");
      start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
         check_stream("restart", k, 32'h0100, 4);
      end
      repeat (24) @(negedge clk);
      check_idle("restart end");

      // Address wrap on a 2-rect copy based at 0xFFFE.
      start2 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (k <= 12) begin
            check_stream("wrap", k, 32'hFFFE, 2);
         end else begin
            check("wrap idle busy", 32'(busy2), 32'd0);
            check("wrap idle addr", 32'(mem_addr2), 32'hFFFE);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
